// File: rtl/carfield_addr_rule_table_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : carfield_addr_rule_table_if
// Brief    : Config register bus and lookup stream of the address rule table.
//            The master drives requests; the slave is the rule table itself.
// Revision : 1.0 - initial release
// ============================================================================
interface carfield_addr_rule_table_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdxWidth  = 4
);
  // Config register bus
  logic                 cfg_req_i;
  logic                 cfg_we_i;
  logic [11:0]          cfg_addr_i;
  logic [31:0]          cfg_wdata_i;
  logic                 cfg_gnt_o;
  logic                 cfg_rvalid_o;
  logic [31:0]          cfg_rdata_o;
  logic                 cfg_error_o;
  // Lookup stream
  logic                 lk_valid_i;
  logic                 lk_ready_o;
  logic [AddrWidth-1:0] lk_addr_i;
  logic                 lk_valid_o;
  logic                 lk_ready_i;
  logic [IdxWidth-1:0]  lk_idx_o;
  logic                 lk_hit_o;

  modport master (
    output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_error_o,
    output lk_valid_i, lk_addr_i, lk_ready_i,
    input  lk_ready_o, lk_valid_o, lk_idx_o, lk_hit_o
  );

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_error_o,
    input  lk_valid_i, lk_addr_i, lk_ready_i,
    output lk_ready_o, lk_valid_o, lk_idx_o, lk_hit_o
  );
endinterface
`default_nettype wire

// File: rtl/carfield_addr_rule_table.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : carfield_addr_rule_table
// Brief    : Programmable base/size/enable address map. Software programs the
//            rules over a register bus (lockable); a one-stage pipelined lookup
//            returns the target index of the lowest matching rule, and misses
//            are counted with first-miss address capture and a level IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module carfield_addr_rule_table #(
  parameter int unsigned NumRules   = 8,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned NumTargets = 16,
  parameter int unsigned DefaultIdx = 0
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_ni,
  carfield_addr_rule_table_if.slave  bus,
  output logic                       irq_o
);

  localparam int unsigned IdxWidth = (NumTargets > 1) ? $clog2(NumTargets) : 1;
  localparam logic [IdxWidth-1:0] DefIdx = IdxWidth'(DefaultIdx);

  // Rule table and global registers
  logic [AddrWidth-1:0] base_q [NumRules];
  logic [AddrWidth-1:0] size_q [NumRules];
  logic [IdxWidth-1:0]  idx_q  [NumRules];
  logic                 en_q   [NumRules];
  logic                 lock_q, irq_en_q, irq_q;
  logic [15:0]          miss_cnt_q, miss_cnt_d;
  logic [AddrWidth-1:0] miss_addr_q, miss_addr_d;
  // Response / result registers
  logic                 cfg_rvalid_q, cfg_error_q;
  logic [31:0]          cfg_rdata_q;
  logic                 lk_valid_q, lk_hit_q;
  logic [IdxWidth-1:0]  lk_idx_q;

  // Config address decode: 16-byte slot per rule, globals at 0x100..0x10C
  logic [3:0]  w_rule;
  logic [1:0]  w_reg;
  logic        w_is_rule, w_is_glb, w_ctrl_bad, w_err, w_wr;
  logic [31:0] w_rdata;
  logic        w_hit, w_lk_acc, w_cnt_clr;
  logic [IdxWidth-1:0] w_idx;
  logic        unused_addr_lsb;

  assign w_rule    = bus.cfg_addr_i[7:4];
  assign w_reg     = bus.cfg_addr_i[3:2];
  assign w_is_rule = (bus.cfg_addr_i[11:8] == 4'd0) && ({28'd0, w_rule} < NumRules)
                     && (w_reg != 2'd3);
  assign w_is_glb  = (bus.cfg_addr_i[11:4] == 8'h10);
  // The whole field above EN is treated as IDX so out-of-range values wider
  // than IdxWidth are rejected rather than silently truncated.
  assign w_ctrl_bad = (w_reg == 2'd2) && ({4'd0, bus.cfg_wdata_i[31:4]} >= NumTargets);
  assign w_err     = !(w_is_rule || w_is_glb)
                     || (bus.cfg_we_i && w_is_rule && (lock_q || w_ctrl_bad));
  assign w_wr      = bus.cfg_req_i && bus.cfg_we_i && !w_err;
  assign w_cnt_clr = w_wr && w_is_glb && (w_reg == 2'd1);
  assign unused_addr_lsb = ^bus.cfg_addr_i[1:0];

  assign bus.cfg_gnt_o    = bus.cfg_req_i;
  assign bus.cfg_rvalid_o = cfg_rvalid_q;
  assign bus.cfg_error_o  = cfg_error_q;
  assign bus.cfg_rdata_o  = cfg_rdata_q;
  assign bus.lk_ready_o   = !lk_valid_q || bus.lk_ready_i;
  assign bus.lk_valid_o   = lk_valid_q;
  assign bus.lk_idx_o     = lk_idx_q;
  assign bus.lk_hit_o     = lk_hit_q;
  assign irq_o            = irq_q;
  assign w_lk_acc         = bus.lk_valid_i && bus.lk_ready_o;

  // Read data mux for mapped registers; unused bits read as zero
  always_comb begin
    w_rdata = '0;
    if (w_is_rule) begin
      for (int r = 0; r < int'(NumRules); r++) begin
        if (w_rule == 4'(r)) begin
          case (w_reg)
            2'd0:    w_rdata = 32'(base_q[r]);
            2'd1:    w_rdata = 32'(size_q[r]);
            2'd2:    w_rdata = 32'({idx_q[r], 3'b000, en_q[r]});
            default: w_rdata = '0;
          endcase
        end
      end
    end else if (w_is_glb) begin
      case (w_reg)
        2'd0:    w_rdata = {31'd0, lock_q};
        2'd1:    w_rdata = {16'd0, miss_cnt_q};
        2'd2:    w_rdata = 32'(miss_addr_q);
        default: w_rdata = {31'd0, irq_en_q};
      endcase
    end
  end

  // Priority match: iterate high to low so the lowest matching rule wins
  always_comb begin
    w_hit = 1'b0;
    w_idx = DefIdx;
    for (int r = int'(NumRules) - 1; r >= 0; r--) begin
      if (en_q[r] && ((bus.lk_addr_i - base_q[r]) < size_q[r])
          && (bus.lk_addr_i >= base_q[r])) begin
        w_hit = 1'b1;
        w_idx = idx_q[r];
      end
    end
  end

  // Miss accounting next state: a same-cycle counter write beats the miss
  always_comb begin
    miss_cnt_d  = miss_cnt_q;
    miss_addr_d = miss_addr_q;
    if (w_cnt_clr) begin
      miss_cnt_d = '0;
    end else if (w_lk_acc && !w_hit) begin
      if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      if (miss_cnt_q == 16'd0)    miss_addr_d = bus.lk_addr_i;
    end
  end

  // Rule table writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < int'(NumRules); r++) begin
        base_q[r] <= '0;
        size_q[r] <= '0;
        idx_q[r]  <= '0;
        en_q[r]   <= 1'b0;
      end
    end else if (w_wr && w_is_rule) begin
      for (int r = 0; r < int'(NumRules); r++) begin
        if (w_rule == 4'(r)) begin
          case (w_reg)
            2'd0: base_q[r] <= bus.cfg_wdata_i[AddrWidth-1:0];
            2'd1: size_q[r] <= bus.cfg_wdata_i[AddrWidth-1:0];
            default: begin
              idx_q[r] <= bus.cfg_wdata_i[IdxWidth+3:4];
              en_q[r]  <= bus.cfg_wdata_i[0];
            end
          endcase
        end
      end
    end
  end

  // Global registers: lock (set-only), irq enable, miss state, irq level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      miss_cnt_q  <= '0;
      miss_addr_q <= '0;
    end else begin
      if (w_wr && w_is_glb && (w_reg == 2'd0) && bus.cfg_wdata_i[0]) lock_q <= 1'b1;
      if (w_wr && w_is_glb && (w_reg == 2'd3)) irq_en_q <= bus.cfg_wdata_i[0];
      irq_q       <= irq_en_q && (miss_cnt_q != 16'd0);
      miss_cnt_q  <= miss_cnt_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Config response, one cycle after the grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_q <= 1'b0;
      cfg_error_q  <= 1'b0;
      cfg_rdata_q  <= '0;
    end else begin
      cfg_rvalid_q <= bus.cfg_req_i;
      cfg_error_q  <= bus.cfg_req_i && w_err;
      cfg_rdata_q  <= (bus.cfg_req_i && !bus.cfg_we_i && !w_err) ? w_rdata : 32'd0;
    end
  end

  // Lookup result stage; result held while downstream stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_idx_q   <= '0;
    end else if (w_lk_acc) begin
      lk_valid_q <= 1'b1;
      lk_hit_q   <= w_hit;
      lk_idx_q   <= w_idx;
    end else if (bus.lk_ready_i) begin
      lk_valid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_carfield_addr_rule_table.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_carfield_addr_rule_table
// Brief    : Self-checking bench for carfield_addr_rule_table (8 rules,
//            32-bit addresses, 16 targets, default index 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_carfield_addr_rule_table;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic irq_o;
  int   n_chk = 0;
  int   n_err = 0;

  carfield_addr_rule_table_if #(.AddrWidth(32), .IdxWidth(4)) bus ();

  carfield_addr_rule_table #(
    .NumRules(8), .AddrWidth(32), .NumTargets(16), .DefaultIdx(0)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus),
    .irq_o (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  logic [31:0] m_base [8];
  logic [31:0] m_size [8];
  logic [3:0]  m_idx  [8];
  bit          m_en   [8];
  bit          m_lock, m_irqen, m_ov;
  int unsigned m_cnt;
  logic [31:0] m_maddr;

  logic [31:0] one_addr;
  logic [31:0] bp_addr [4];
  bit          last_hit;
  logic [3:0]  last_idx;

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;
  vec_t vt [19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int r = 0; r < 8; r++) begin
      m_base[r] = '0; m_size[r] = '0; m_idx[r] = '0; m_en[r] = 1'b0;
    end
    m_lock = 0; m_irqen = 0; m_ov = 0; m_cnt = 0; m_maddr = '0;
  endfunction

  // First rule (lowest index) whose [base, base+size) holds a, in 64-bit math
  function automatic void m_lookup(input logic [31:0] a, output bit hit, output logic [3:0] idx);
    logic [63:0] aa, lo, hi;
    hit = 0; idx = 4'd0;
    aa = 64'(a);
    for (int r = 0; r < 8; r++) begin
      lo = 64'(m_base[r]);
      hi = lo + 64'(m_size[r]);
      if (!hit && m_en[r] && aa >= lo && aa < hi) begin
        hit = 1; idx = m_idx[r];
      end
    end
  endfunction

  function automatic void m_accept(input logic [31:0] a, output bit hit, output logic [3:0] idx);
    m_lookup(a, hit, idx);
    if (!hit) begin
      if (m_cnt == 0) m_maddr = a;
      if (m_cnt < 32'hFFFF) m_cnt++;
    end
  endfunction

  function automatic void m_cfg(input bit we, input logic [11:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output bit err);
    int off, r, k;
    off = int'(addr) & 'hFFC;
    r = off / 16;
    k = (off % 16) / 4;
    rd = '0; err = 0;
    if (off < 'h100) begin
      if (r >= 8 || k == 3) err = 1;
      else if (we) begin
        if (m_lock || (k == 2 && wd[31:4] >= 28'd16)) err = 1;
        else if (k == 0) m_base[r] = wd;
        else if (k == 1) m_size[r] = wd;
        else begin m_idx[r] = wd[7:4]; m_en[r] = wd[0]; end
      end else begin
        if (k == 0) rd = m_base[r];
        else if (k == 1) rd = m_size[r];
        else rd = {24'd0, m_idx[r], 3'd0, m_en[r]};
      end
    end else if (off <= 'h10C) begin
      case (k)
        0: if (we) begin if (wd[0]) m_lock = 1; end else rd = {31'd0, m_lock};
        1: if (we) m_cnt = 0; else rd = m_cnt;
        2: if (!we) rd = m_maddr;
        default: if (we) m_irqen = wd[0]; else rd = {31'd0, m_irqen};
      endcase
    end else err = 1;
  endfunction

  function automatic logic [31:0] pick_addr();
    int r = $urandom_range(0, 7);
    case ($urandom_range(0, 4))
      0: return m_base[r];
      1: return m_base[r] - 32'd1;
      2: return m_base[r] + m_size[r] - 32'd1;
      3: return m_base[r] + m_size[r];
      default: return $urandom();
    endcase
  endfunction

  function automatic void pick_cfg(output logic [11:0] ca, output logic [31:0] cd);
    int r = $urandom_range(0, 7);
    int k = $urandom_range(0, 9);
    if (k == 9) begin
      ca = 12'h104; cd = $urandom();
    end else begin
      ca = 12'(r * 16 + (k % 3) * 4);
      case (k % 3)
        0: cd = $urandom() & 32'hF00F_FFFF;
        1: cd = ($urandom_range(0, 5) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 24));
        default: cd = {24'd0, 4'($urandom_range(0, 15)), 3'd0, 1'($urandom_range(0, 1))};
      endcase
    end
  endfunction

  // One config access; returns DUT response and the model's expectation
  task automatic cfg(input bit we, input logic [11:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output bit er,
                     output logic [31:0] mrd, output bit mer);
    bus.cfg_req_i = 1'b1; bus.cfg_we_i = we; bus.cfg_addr_i = addr; bus.cfg_wdata_i = wd;
    #1;
    check("cfg_gnt_o", 32'(bus.cfg_gnt_o), 32'd1);
    @(posedge clk_i); #1;
    bus.cfg_req_i = 1'b0;
    check("cfg_rvalid_o", 32'(bus.cfg_rvalid_o), 32'd1);
    rd = bus.cfg_rdata_o;
    er = bus.cfg_error_o;
    m_cfg(we, addr, wd, mrd, mer);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
    logic [31:0] rd, mrd; bit er, mer;
    cfg(1'b1, addr, wd, rd, er, mrd, mer);
    check($sformatf("wr_err@%h", addr), 32'(er), 32'(mer));
  endtask

  task automatic rd_chk(input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd, mrd; bit er, mer;
    cfg(1'b0, addr, 32'd0, rd, er, mrd, mer);
    check($sformatf("rd@%h", addr), rd, exp);
    check($sformatf("rd_err@%h", addr), 32'(er), 32'd0);
  endtask

  // Lookup stream: mode 0 = one_addr, 1 = backpressure pattern, 2 = random
  task automatic stream(input int n, input int mode);
    logic [31:0] eq [$];
    int sent = 0, got = 0, cyc = 0;
    bit rdy, acc, cw, ehit, irq_n, m_irq, edum;
    logic [3:0]  eidx;
    logic [31:0] a, cd, rdum;
    logic [11:0] ca;
    m_irq = m_irqen && (m_cnt != 0);
    while (got < n && cyc < 1000) begin
      rdy = (mode == 2) ? ($urandom_range(0, 3) != 0) : (mode == 1) ? !(cyc >= 1 && cyc <= 3) : 1'b1;
      a   = (mode == 2) ? pick_addr() : (mode == 1) ? bp_addr[sent % 4] : one_addr;
      cw  = (mode == 2) && ($urandom_range(0, 4) == 0);
      ca = 12'd0; cd = 32'd0; edum = 0;
      if (cw) pick_cfg(ca, cd);
      bus.lk_ready_i = rdy; bus.lk_valid_i = (sent < n); bus.lk_addr_i = a;
      bus.cfg_req_i = cw; bus.cfg_we_i = 1'b1; bus.cfg_addr_i = ca; bus.cfg_wdata_i = cd;
      #1;
      check("lk_ready_o", 32'(bus.lk_ready_o), 32'(!m_ov || rdy));
      check("lk_valid_o", 32'(bus.lk_valid_o), 32'(m_ov));
      if (m_ov && eq.size() > 0) begin
        check("lk_result", {27'd0, bus.lk_hit_o, bus.lk_idx_o}, eq[0]);
        if (rdy) begin
          last_hit = bus.lk_hit_o; last_idx = bus.lk_idx_o;
          void'(eq.pop_front()); got++;
        end
      end
      acc   = (sent < n) && (!m_ov || rdy);
      irq_n = m_irqen && (m_cnt != 0);
      if (acc) begin
        m_accept(a, ehit, eidx);
        eq.push_back({27'd0, ehit, eidx});
        sent++;
      end
      if (cw) m_cfg(1'b1, ca, cd, rdum, edum);
      m_ov = acc || (m_ov && !rdy);
      @(posedge clk_i); #1;
      bus.lk_valid_i = 1'b0; bus.cfg_req_i = 1'b0; bus.lk_ready_i = 1'b1;
      m_irq = irq_n;
      check("irq_o", 32'(irq_o), 32'(m_irq));
      check("cfg_rvalid_o", 32'(bus.cfg_rvalid_o), 32'(cw));
      if (cw) check("cfg_error_o", 32'(bus.cfg_error_o), 32'(edum));
      cyc++;
    end
    if (got < n) begin
      n_chk++; n_err++;
      $display("FAIL stream_timeout: got %0d results, required %0d", got, n);
    end
  endtask

  task automatic look(input logic [31:0] a, input bit hit, input logic [3:0] idx);
    one_addr = a;
    stream(1, 0);
    check($sformatf("look_hit@%h", a), 32'(last_hit), 32'(hit));
    check($sformatf("look_idx@%h", a), 32'(last_idx), 32'(idx));
  endtask

  initial begin
    logic [31:0] rd, mrd;
    bit er, mer, h;
    logic [3:0] ix;

    vt[0]  = '{0, 12'h000, 32'h0,        32'h0,        0};
    vt[1]  = '{0, 12'h104, 32'h0,        32'h0,        0};
    vt[2]  = '{0, 12'h108, 32'h0,        32'h0,        0};
    vt[3]  = '{0, 12'h10C, 32'h0,        32'h0,        0};
    vt[4]  = '{1, 12'h000, 32'h50000000, 32'h0,        0};
    vt[5]  = '{1, 12'h004, 32'h00800000, 32'h0,        0};
    vt[6]  = '{1, 12'h008, 32'h00000031, 32'h0,        0};
    vt[7]  = '{0, 12'h000, 32'h0,        32'h50000000, 0};
    vt[8]  = '{0, 12'h004, 32'h0,        32'h00800000, 0};
    vt[9]  = '{0, 12'h008, 32'h0,        32'h00000031, 0};
    vt[10] = '{0, 12'h00C, 32'h0,        32'h0,        1};
    vt[11] = '{0, 12'h200, 32'h0,        32'h0,        1};
    vt[12] = '{0, 12'h080, 32'h0,        32'h0,        1};
    vt[13] = '{1, 12'h018, 32'h00000101, 32'h0,        1};
    vt[14] = '{0, 12'h018, 32'h0,        32'h0,        0};
    vt[15] = '{1, 12'h110, 32'h1,        32'h0,        1};
    vt[16] = '{0, 12'h00B, 32'h0,        32'h00000031, 0};
    vt[17] = '{1, 12'h108, 32'h123,      32'h0,        0};
    vt[18] = '{0, 12'h108, 32'h0,        32'h0,        0};
    bp_addr[0] = 32'h50000004; bp_addr[1] = 32'h90000000;
    bp_addr[2] = 32'hFFFFFFF0; bp_addr[3] = 32'h50000FFF;

    rst_ni = 1'b0;
    bus.cfg_req_i = 0; bus.cfg_we_i = 0; bus.cfg_addr_i = '0; bus.cfg_wdata_i = '0;
    bus.lk_valid_i = 0; bus.lk_addr_i = '0; bus.lk_ready_i = 1;
    m_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reset state
    check("rst_cfg_rvalid", 32'(bus.cfg_rvalid_o), 32'd0);
    check("rst_cfg_error",  32'(bus.cfg_error_o),  32'd0);
    check("rst_cfg_rdata",  bus.cfg_rdata_o,       32'd0);
    check("rst_lk_valid",   32'(bus.lk_valid_o),   32'd0);
    check("rst_lk_out",     {27'd0, bus.lk_hit_o, bus.lk_idx_o}, 32'd0);
    check("rst_irq",        32'(irq_o),            32'd0);
    check("rst_lk_ready",   32'(bus.lk_ready_o),   32'd1);

    // Register map vectors
    for (int i = 0; i < 19; i++) begin
      cfg(vt[i].we, vt[i].addr, vt[i].wdata, rd, er, mrd, mer);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].err));
    end

    // Rule 0 edges and miss capture
    look(32'h507FFFFF, 1, 4'd3);
    look(32'h50800000, 0, 4'd0);
    rd_chk(12'h104, 32'd1);
    rd_chk(12'h108, 32'h50800000);

    // Overlap priority
    wr(12'h010, 32'h50000000); wr(12'h014, 32'h1000); wr(12'h018, 32'h51);
    look(32'h50000010, 1, 4'd3);
    wr(12'h008, 32'h30);
    look(32'h50000010, 1, 4'd5);

    // Wrap past the top of the address space
    wr(12'h020, 32'hFFFFF000); wr(12'h024, 32'h2000); wr(12'h028, 32'h71);
    look(32'hFFFFFFFF, 1, 4'd7);
    look(32'h00000000, 0, 4'd0);

    // IRQ timing and clear-wins-over-miss
    wr(12'h104, 32'd0);
    wr(12'h10C, 32'd1);
    check("irq_idle", 32'(irq_o), 32'd0);
    bus.lk_valid_i = 1; bus.lk_addr_i = 32'h60000000; bus.lk_ready_i = 1;
    m_accept(32'h60000000, h, ix);
    @(posedge clk_i); #1;
    bus.lk_valid_i = 0;
    check("irq_result_hit", 32'(bus.lk_hit_o), 32'd0);
    check("irq_same_cycle", 32'(irq_o), 32'd0);
    @(posedge clk_i); #1;
    check("irq_next_cycle", 32'(irq_o), 32'd1);
    bus.lk_valid_i = 1; bus.lk_addr_i = 32'h70000000;
    bus.cfg_req_i = 1; bus.cfg_we_i = 1; bus.cfg_addr_i = 12'h104; bus.cfg_wdata_i = 32'd0;
    m_accept(32'h70000000, h, ix);
    m_cfg(1'b1, 12'h104, 32'd0, mrd, mer);
    @(posedge clk_i); #1;
    bus.lk_valid_i = 0; bus.cfg_req_i = 0;
    check("irq_clear_lag", 32'(irq_o), 32'd1);
    @(posedge clk_i); #1;
    check("irq_cleared", 32'(irq_o), 32'd0);
    rd_chk(12'h104, 32'd0);
    rd_chk(12'h108, 32'h60000000);

    // Backpressure: 4 lookups, downstream stalled for 3 cycles
    stream(4, 1);

    // Randomised traffic with concurrent rule rewrites
    stream(300, 2);
    rd_chk(12'h104, m_cnt);
    rd_chk(12'h108, m_maddr);

    // Lock
    wr(12'h100, 32'd1);
    cfg(1'b1, 12'h000, 32'h12345678, rd, er, mrd, mer);
    check("locked_wr_err", 32'(er), 32'd1);
    rd_chk(12'h000, m_base[0]);
    rd_chk(12'h100, 32'd1);
    wr(12'h10C, 32'd0);
    rd_chk(12'h10C, 32'd0);

    // Reset mid-operation drops pending responses immediately
    bus.lk_valid_i = 1; bus.lk_addr_i = 32'h50000010; bus.lk_ready_i = 0;
    bus.cfg_req_i = 1; bus.cfg_we_i = 0; bus.cfg_addr_i = 12'h000;
    @(posedge clk_i); #1;
    bus.lk_valid_i = 0; bus.cfg_req_i = 0;
    check("pre_rst_lk_valid", 32'(bus.lk_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_lk_valid", 32'(bus.lk_valid_o), 32'd0);
    check("mid_rst_cfg_rvalid", 32'(bus.cfg_rvalid_o), 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    m_reset();
    bus.lk_ready_i = 1;
    rd_chk(12'h100, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
